// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
package mem_arb_pkg;

    // Request container widths; the top casts its own ADDR_W/DATA_W into these.
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int REQ_MASK_W = REQ_DATA_W / 8;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic                  wen;
        logic [REQ_DATA_W-1:0] wdata;
        logic [REQ_MASK_W-1:0] wmask;
    } req_t;

endpackage

// File: rtl/mem_arb_slot.sv
// rtl/mem_arb_slot.sv - per-port pending flag plus holding register
module mem_arb_slot
    import mem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    input  req_t req_in,
    input  logic is_owner,
    input  logic grant,
    output logic cand,
    output req_t current
);

    logic pending;
    req_t held;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            held    <= '0;
        end else if (grant) begin
            pending <= 1'b0;
        end else if (req_valid && !is_owner) begin
            pending <= 1'b1;
            held    <= req_in;
        end
    end

    // A live request is always newer than whatever is held.
    assign cand    = pending | req_valid;
    assign current = req_valid ? req_in : held;

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - merges IFU and LSU requests onto one memory bus, one transaction at a time
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W       = REQ_ADDR_W,
    parameter int                DATA_W       = REQ_DATA_W,
    parameter int                TIMEOUT_CYC  = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [1:0]          lsu_size,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_reqValid,
    input  logic                mem_reqReady,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [1:0]          mem_size,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       state;
    owner_t           owner;
    req_t             mem_q;
    logic [CNT_W-1:0] cnt;

    req_t ifu_in, lsu_in, ifu_cur, lsu_cur;
    logic ifu_cand, lsu_cand;
    logic busy, grant_ifu, grant_lsu;
    logic mem_hit, expired, do_resp;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        ifu_in       = '0;
        ifu_in.addr  = REQ_ADDR_W'(ifu_addr);
        ifu_in.size  = SIZE_WORD;
        lsu_in       = '0;
        lsu_in.addr  = REQ_ADDR_W'(lsu_addr);
        lsu_in.size  = lsu_size;
        lsu_in.wen   = lsu_wen;
        lsu_in.wdata = REQ_DATA_W'(lsu_wdata);
        lsu_in.wmask = REQ_MASK_W'(lsu_wmask);
    end

    // Ownership only masks capture while the transaction is on the bus;
    // a request seen during RESP is a new one and must be remembered.
    assign busy      = (state == ARB_REQ) || (state == ARB_WAIT);
    assign grant_lsu = (state == ARB_IDLE) && lsu_cand;
    assign grant_ifu = (state == ARB_IDLE) && !lsu_cand && ifu_cand;

    mem_arb_slot u_ifu_slot (
        .clock     (clock),
        .reset     (reset),
        .req_valid (ifu_reqValid),
        .req_in    (ifu_in),
        .is_owner  (busy && (owner == OWN_IFU)),
        .grant     (grant_ifu),
        .cand      (ifu_cand),
        .current   (ifu_cur)
    );

    mem_arb_slot u_lsu_slot (
        .clock     (clock),
        .reset     (reset),
        .req_valid (lsu_reqValid),
        .req_in    (lsu_in),
        .is_owner  (busy && (owner == OWN_LSU)),
        .grant     (grant_lsu),
        .cand      (lsu_cand),
        .current   (lsu_cur)
    );

    // A real response in the final WAIT cycle beats the timeout; in REQ the
    // timeout wins even over a same-edge handshake.
    assign mem_hit   = (state == ARB_WAIT) && mem_respValid;
    assign expired   = busy && (cnt == CNT_W'(TIMEOUT_CYC - 1)) && !mem_hit;
    assign do_resp   = mem_hit || expired;
    assign resp_data = mem_hit ? mem_rdata : TIMEOUT_DATA;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            owner         <= OWN_IFU;
            mem_q         <= '0;
            cnt           <= '0;
            mem_reqValid  <= 1'b0;
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rdata     <= '0;
            timeout       <= 1'b0;
        end else begin
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        owner        <= grant_lsu ? OWN_LSU : OWN_IFU;
                        mem_q        <= grant_lsu ? lsu_cur : ifu_cur;
                        mem_reqValid <= 1'b1;
                        cnt          <= '0;
                        state        <= ARB_REQ;
                    end
                end
                ARB_REQ, ARB_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (do_resp) begin
                        mem_reqValid <= 1'b0;
                        state        <= ARB_RESP;
                        if (expired) begin
                            timeout <= 1'b1;
                        end
                        if (owner == OWN_LSU) begin
                            lsu_respValid <= 1'b1;
                            lsu_rdata     <= resp_data;
                        end else begin
                            ifu_respValid <= 1'b1;
                            ifu_rdata     <= resp_data;
                        end
                    end else if ((state == ARB_REQ) && mem_reqReady) begin
                        mem_reqValid <= 1'b0;
                        state        <= ARB_WAIT;
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = ADDR_W'(mem_q.addr);
    assign mem_size  = mem_q.size;
    assign mem_wen   = mem_q.wen;
    assign mem_wdata = DATA_W'(mem_q.wdata);
    assign mem_wmask = MASK_W'(mem_q.wmask);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb with a behavioural memory and scoreboard
module tb_mem_arb;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        timeout;

    mem_arb #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .TIMEOUT_CYC  (TO),
        .TIMEOUT_DATA (32'hDEAD_BEEF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_size      (lsu_size),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_reqReady  (mem_reqReady),
        .mem_addr      (mem_addr),
        .mem_size      (mem_size),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .timeout       (timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          edge_n;
    } acc_t;

    typedef struct {
        bit          port;      // 0 = IFU, 1 = LSU
        logic [31:0] data;
        int          edge_n;
    } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] mdata_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int mem_lat = 1;
    int resp_cd = 0;
    int stall = 0;
    bit force_low = 1'b0;
    bit neg_rv;
    acc_t neg_req;
    bit prev_ifu = 1'b0;
    bit prev_lsu = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("rsp_count", 64'(rsp_q.size()), 64'(n));
    endtask

    // Memory model: samples the request at negedge, acts 2 units after each edge.
    initial forever begin
        @(negedge clock);
        neg_rv        = mem_reqValid;
        neg_req.addr  = mem_addr;
        neg_req.size  = mem_size;
        neg_req.wen   = mem_wen;
        neg_req.wdata = mem_wdata;
        neg_req.wmask = mem_wmask;
    end

    initial begin
        mem_reqReady  = 1'b1;
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(posedge clock);
            #2;
            mem_respValid = 1'b0;
            if (!reset) begin
                resp_cd = 0;
            end else begin
                if (resp_cd > 0) begin
                    resp_cd--;
                    if (resp_cd == 0) begin
                        mem_respValid = 1'b1;
                        if (mdata_q.size() > 0) mem_rdata = mdata_q.pop_front();
                        else mem_rdata = 32'h0;
                    end
                end
                if (neg_rv && mem_reqReady) begin
                    neg_req.edge_n = cyc;
                    acc_q.push_back(neg_req);
                    resp_cd = mem_lat;
                end
            end
            mem_reqReady = !(force_low || stall > 0);
            if (stall > 0) stall--;
        end
    end

    // Response monitor: strobes must be single-cycle and mutually exclusive.
    initial forever begin
        rsp_t r;
        @(negedge clock);
        if (ifu_respValid || lsu_respValid)
            chk("resp_exclusive", 64'(ifu_respValid & lsu_respValid), 64'(0));
        if (ifu_respValid) begin
            chk("ifu_strobe_len", 64'(prev_ifu), 64'(0));
            r.port = 1'b0; r.data = ifu_rdata; r.edge_n = cyc;
            rsp_q.push_back(r);
        end
        if (lsu_respValid) begin
            chk("lsu_strobe_len", 64'(prev_lsu), 64'(0));
            r.port = 1'b1; r.data = lsu_rdata; r.edge_n = cyc;
            rsp_q.push_back(r);
        end
        prev_ifu = ifu_respValid;
        prev_lsu = lsu_respValid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, sel, n, idx;
        logic [31:0] ia, la, lwd, d0, d1, last_ifu, last_lsu;
        logic [1:0]  ls;
        logic        lw;
        logic [3:0]  lm;

        reset = 1'b0;
        ifu_reqValid = 0; ifu_addr = 0;
        lsu_reqValid = 0; lsu_addr = 0; lsu_size = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        tick(); tick();
        chk("rst_strobes", {ifu_respValid, lsu_respValid, mem_reqValid, timeout}, 0);
        chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
        chk("rst_mem_fields", {mem_addr, mem_size, mem_wen, mem_wmask}, 0);
        reset = 1'b1;
        tick();

        // Single fetch with exact latency
        acc_q.delete(); rsp_q.delete();
        mem_lat = 1;
        mdata_q.push_back(32'h0010_0093);
        ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
        tick(); g = cyc;
        ifu_reqValid = 0;
        chk("fetch_reqvalid_n1", 64'(mem_reqValid), 1);
        chk("fetch_mem_fields", {mem_addr, mem_size, mem_wen, mem_wmask}, {32'h8000_0000, 2'b10, 1'b0, 4'h0});
        wait_rsp(1, 20);
        chk("fetch_port", 64'(rsp_q[0].port), 0);
        chk("fetch_data", rsp_q[0].data, 32'h0010_0093);
        chk("fetch_latency", 64'(rsp_q[0].edge_n), 64'(g + 3));
        tick(); tick(); tick();
        chk("fetch_no_lsu", 64'(rsp_q.size()), 1);

        // Collision: LSU wins, IFU follows right after LSU's RESP
        acc_q.delete(); rsp_q.delete();
        mdata_q.push_back(32'h2222_0200);
        mdata_q.push_back(32'h1111_0100);
        ifu_reqValid = 1; ifu_addr = 32'h100;
        lsu_reqValid = 1; lsu_addr = 32'h200; lsu_wen = 0; lsu_size = 2'b10; lsu_wmask = 0; lsu_wdata = 0;
        tick();
        ifu_reqValid = 0; lsu_reqValid = 0;
        wait_rsp(2, 40);
        chk("coll_first_addr", acc_q[0].addr, 32'h200);
        chk("coll_second_addr", acc_q[1].addr, 32'h100);
        chk("coll_first_port", 64'(rsp_q[0].port), 1);
        chk("coll_first_data", rsp_q[0].data, 32'h2222_0200);
        chk("coll_second_port", 64'(rsp_q[1].port), 0);
        chk("coll_second_data", rsp_q[1].data, 32'h1111_0100);
        chk("coll_gap", 64'(rsp_q[1].edge_n - rsp_q[0].edge_n), 5);
        tick(); tick();

        // Store held stable under 5 cycles of backpressure
        acc_q.delete(); rsp_q.delete();
        force_low = 1;
        mdata_q.push_back(32'h0000_0000);
        lsu_reqValid = 1; lsu_addr = 32'h204; lsu_wen = 1; lsu_size = 2'b10;
        lsu_wdata = 32'hAABB_CCDD; lsu_wmask = 4'b1111;
        tick();
        lsu_reqValid = 0; lsu_wen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("store_hold_hdr", {mem_reqValid, mem_wen, mem_wmask, mem_size, mem_addr},
                {1'b1, 1'b1, 4'hF, 2'b10, 32'h204});
            chk("store_hold_wdata", mem_wdata, 32'hAABB_CCDD);
        end
        force_low = 0;
        wait_rsp(1, 20);
        chk("store_accepts", 64'(acc_q.size()), 1);
        chk("store_port", 64'(rsp_q[0].port), 1);
        chk("store_ack_latency", 64'(rsp_q[0].edge_n), 64'(acc_q[0].edge_n + 2));
        tick(); tick();

        // Backpressure: exactly one handshake after ready returns
        acc_q.delete(); rsp_q.delete();
        force_low = 1;
        mdata_q.push_back(32'h3030_3030);
        ifu_reqValid = 1; ifu_addr = 32'h300;
        tick(); g = cyc;
        ifu_reqValid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_reqvalid_held", 64'(mem_reqValid), 1);
            tick();
        end
        force_low = 0;
        wait_rsp(1, 20);
        tick(); tick(); tick();
        chk("bp_accepts", 64'(acc_q.size()), 1);
        chk("bp_accept_edge", 64'(acc_q[0].edge_n), 64'(g + 4));
        chk("bp_data", rsp_q[0].data, 32'h3030_3030);
        chk("bp_reqvalid_low", 64'(mem_reqValid), 0);

        // Timeout: memory answers far too late
        acc_q.delete(); rsp_q.delete();
        mem_lat = 20;
        lsu_reqValid = 1; lsu_addr = 32'h400; lsu_wen = 0;
        tick(); g = cyc;
        lsu_reqValid = 0;
        wait_rsp(1, 40);
        chk("to_port", 64'(rsp_q[0].port), 1);
        chk("to_data", rsp_q[0].data, 32'hDEAD_BEEF);
        chk("to_edge", 64'(rsp_q[0].edge_n), 64'(g + TO));
        chk("to_flag", 64'(timeout), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("to_late_ignored", 64'(rsp_q.size()), 1);
        chk("to_sticky", 64'(timeout), 1);
        chk("to_lsu_rdata_kept", lsu_rdata, 32'hDEAD_BEEF);

        // Async reset while WAITing
        acc_q.delete(); rsp_q.delete();
        mem_lat = 10;
        ifu_reqValid = 1; ifu_addr = 32'h500;
        tick();
        ifu_reqValid = 0;
        tick(); tick();
        #3;
        reset = 1'b0;
        #1;
        chk("arst_strobes", {ifu_respValid, lsu_respValid, mem_reqValid, timeout}, 0);
        chk("arst_rdata", {ifu_rdata, lsu_rdata}, 0);
        chk("arst_mem_fields", {mem_addr, mem_wdata}, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        acc_q.delete(); rsp_q.delete();
        mem_lat = 1;
        mdata_q.push_back(32'h1234_5678);
        ifu_reqValid = 1; ifu_addr = 32'h600;
        tick(); g = cyc;
        ifu_reqValid = 0;
        wait_rsp(1, 20);
        chk("arst_after_addr", acc_q[0].addr, 32'h600);
        chk("arst_after_data", rsp_q[0].data, 32'h1234_5678);
        chk("arst_after_edge", 64'(rsp_q[0].edge_n), 64'(g + 3));
        tick(); tick();

        // Randomized rounds against the ordering/routing rules
        last_ifu = 32'h1234_5678;
        last_lsu = 32'h0;
        for (int r = 0; r < 24; r++) begin
            acc_q.delete(); rsp_q.delete();
            sel = $urandom_range(1, 3);
            mem_lat = $urandom_range(1, 3);
            stall = $urandom_range(0, 3);
            ia = $urandom & 32'hFFFF_FFFC;
            la = $urandom;
            lw = 1'($urandom_range(0, 1));
            lwd = $urandom;
            lm = 4'($urandom_range(0, 15));
            ls = 2'($urandom_range(0, 2));
            d0 = $urandom;
            d1 = $urandom;
            n = (sel == 3) ? 2 : 1;
            mdata_q.push_back(d0);
            if (n == 2) mdata_q.push_back(d1);
            ifu_reqValid = sel[0]; ifu_addr = ia;
            lsu_reqValid = sel[1]; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm; lsu_size = ls;
            tick();
            ifu_reqValid = 0; lsu_reqValid = 0;
            wait_rsp(n, 60);
            idx = 0;
            if (sel[1]) begin
                chk("rnd_lsu_req", {acc_q[idx].addr, acc_q[idx].size, acc_q[idx].wen, acc_q[idx].wmask},
                    {la, ls, lw, lm});
                chk("rnd_lsu_wdata", acc_q[idx].wdata, lwd);
                chk("rnd_lsu_port", 64'(rsp_q[idx].port), 1);
                chk("rnd_lsu_data", rsp_q[idx].data, d0);
                last_lsu = d0;
                idx++;
            end
            if (sel[0]) begin
                chk("rnd_ifu_req", {acc_q[idx].addr, acc_q[idx].size, acc_q[idx].wen, acc_q[idx].wmask},
                    {ia, 2'b10, 1'b0, 4'h0});
                chk("rnd_ifu_port", 64'(rsp_q[idx].port), 0);
                chk("rnd_ifu_data", rsp_q[idx].data, (idx == 0) ? d0 : d1);
                last_ifu = (idx == 0) ? d0 : d1;
            end
            tick(); tick();
            chk("rnd_accepts", 64'(acc_q.size()), 64'(n));
            chk("rnd_rdata_held", {ifu_rdata, lsu_rdata}, {last_ifu, last_lsu});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
